// File: rtl/hack_rom_loader.sv
// HACK boot loader: packs a big-endian byte stream into 16-bit words and writes the instruction store.
// Optional checksum trailer is built in when HACK_LOADER_CHECKSUM_EN is defined.
module hack_rom_loader #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [DATA_W-1:0] rom_data,
  output logic              rom_we,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [3:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DAT_HI,
    DAT_LO,
`ifdef HACK_LOADER_CHECKSUM_EN
    CHK_HI,
    CHK_LO,
`endif
    DONE,
    ERR
  } state_t;

  state_t            state;
  state_t            nxt;
  logic [15:0]       lenQ;
  logic [7:0]        hiQ;
  logic [ADDR_W-1:0] idxQ;
  logic [15:0]       newLen;
  logic [15:0]       word;
  logic              fire;
  logic              lastWord;
  logic              startAcc;
`ifdef HACK_LOADER_CHECKSUM_EN
  logic [15:0]       sumQ;
`endif

  assign fire     = byte_valid && byte_ready;
  assign newLen   = {lenQ[15:8], byte_in};
  assign word     = {hiQ, byte_in};
  assign lastWord = (16'(idxQ) == lenQ - 16'd1);
  assign startAcc = start &&
                    (state == IDLE || state == DONE || state == ERR);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  // Next-state logic and state-decoded status outputs.
  always_comb begin
    nxt        = state;
    byte_ready = 1'b0;
    busy       = 1'b0;
    cpu_rst    = 1'b1;
    done       = 1'b0;
    err        = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) nxt = LEN_HI;
      end
      LEN_HI: begin
        if (fire) nxt = LEN_LO;
      end
      LEN_LO: begin
        if (fire) begin
          if (newLen[15])
            nxt = ERR;
          else if (newLen == 16'd0)
`ifdef HACK_LOADER_CHECKSUM_EN
            nxt = CHK_HI;
`else
            nxt = DONE;
`endif
          else
            nxt = DAT_HI;
        end
      end
      DAT_HI: begin
        if (fire) nxt = DAT_LO;
      end
      DAT_LO: begin
        if (fire) begin
          if (lastWord)
`ifdef HACK_LOADER_CHECKSUM_EN
            nxt = CHK_HI;
`else
            nxt = DONE;
`endif
          else
            nxt = DAT_HI;
        end
      end
`ifdef HACK_LOADER_CHECKSUM_EN
      CHK_HI: begin
        if (fire) nxt = CHK_LO;
      end
      CHK_LO: begin
        if (fire) nxt = (word == sumQ) ? DONE : ERR;
      end
`endif
      default: nxt = IDLE;
    endcase
    busy       = !(state == IDLE || state == DONE || state == ERR);
    byte_ready = busy;
    cpu_rst    = (state != DONE);
    done       = (state == DONE);
    err        = (state == ERR);
  end

  // Datapath: length capture, word packing, store writes and word index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lenQ     <= '0;
      hiQ      <= '0;
      idxQ     <= '0;
      rom_addr <= '0;
      rom_data <= '0;
      rom_we   <= 1'b0;
`ifdef HACK_LOADER_CHECKSUM_EN
      sumQ     <= '0;
`endif
    end else begin
      rom_we <= 1'b0;
      if (startAcc) begin
        idxQ <= '0;
`ifdef HACK_LOADER_CHECKSUM_EN
        sumQ <= '0;
`endif
      end
      if (fire) begin
        case (state)
          LEN_HI: lenQ[15:8] <= byte_in;
          LEN_LO: lenQ[7:0]  <= byte_in;
          DAT_HI: hiQ        <= byte_in;
          DAT_LO: begin
            rom_we   <= 1'b1;
            rom_addr <= idxQ;
            rom_data <= word;
            if (!lastWord) idxQ <= idxQ + ADDR_W'(1);
`ifdef HACK_LOADER_CHECKSUM_EN
            sumQ <= sumQ + word;
`endif
          end
`ifdef HACK_LOADER_CHECKSUM_EN
          CHK_HI: hiQ <= byte_in;
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/hack_rom_loader.md
# hack_rom_loader

Boot-time instruction-memory writer for the HACK computer. It receives a program as a byte stream over a valid/ready handshake and packs the bytes into 16-bit instruction words. It writes those words into the instruction store at consecutive 15-bit addresses, starting at address 0. While a load is in progress, it holds the CPU in reset, and it releases the CPU only after a complete, well-formed image has been written.

## Interface
- `ADDR_W`, 15: instruction address width; matches the CPU program-counter address space.
- `DATA_W`, 16: instruction word width; fixed at 16, because the stream format packs two bytes per word.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a load.
- `byte_in`  in  8  stream byte.
- `byte_valid`  in  1  `byte_in` is valid.
- `byte_ready`  out  1  loader accepts `byte_in` this cycle.
- `rom_addr`  out  `ADDR_W`  instruction-store write address.
- `rom_data`  out  `DATA_W`  instruction-store write data.
- `rom_we`  out  1  instruction-store write strobe; one cycle per word.
- `cpu_rst`  out  1  active-high reset to the CPU.
- `busy`  out  1  a load is in progress.
- `done`  out  1  the last load completed successfully.
- `err`  out  1  the last load was rejected.

## Operation
- Stream format, all big-endian:
  - 2 length bytes giving N, the number of words.
  - N words, each sent as a high byte then a low byte.
  - Optionally, a 2-byte checksum (see Configuration).
- A byte transfers only when `byte_valid && byte_ready` on a rising edge.
- States and transitions:
  - IDLE: waits for `start`.
  - LEN_HI: captures the high length byte.
  - LEN_LO: captures the low length byte.
  - DAT_HI: captures the high data byte.
  - DAT_LO: captures the low data byte.
  - CHK_HI, CHK_LO: present only with the Configuration macro.
  - DONE: load complete.
  - ERR: load rejected.
- IDLE, DONE or ERR + `start` → LEN_HI. This clears `done`/`err`, sets `busy`, asserts `cpu_rst` and resets the word index to 0.
- `start` in any other state is ignored.
- LEN_LO → ERR if bit 15 of N is set, because N > 32767 is illegal.
- LEN_LO → DONE (or CHK_HI) if N = 0; no writes occur.
- LEN_LO → DAT_HI otherwise.
- DAT_LO accept: registers `rom_data = {hi,lo}` and `rom_addr = index`, and pulses `rom_we`. Then:
  - if index = N-1, → DONE (or CHK_HI);
  - otherwise, increments index and → DAT_HI.
- `byte_ready` = 1 exactly in the LEN_*, DAT_* and CHK_* states. There is no back-pressure from writes.
- DONE: `cpu_rst` = 0, `done` = 1, `busy` = 0; the CPU executes from address 0.
- ERR: `cpu_rst` = 1, `err` = 1, `busy` = 0. Words already written remain in the store.
- Index arithmetic is 15-bit. Index never wraps, because N ≤ 32767.

## Timing
- Reset values (asynchronous): state IDLE, `byte_ready` 0, `rom_we` 0, `rom_addr` 0, `rom_data` 0, `cpu_rst` 1, `busy` 0, `done` 0, `err` 0.
- `rst` asserted mid-load aborts immediately to the reset values. A partial image stays in the store, and `cpu_rst` stays 1.
- After IDLE, the CPU stays in reset until a successful load completes.
- `start` edge → `busy` = 1 and `byte_ready` = 1 on the next cycle.
- Low-byte accept edge → `rom_we` = 1 for exactly the following cycle, with `rom_addr`/`rom_data` stable in that cycle. `rom_addr`/`rom_data` then hold their values until the next write.
- Minimum rate is one byte per cycle. A new high byte may be accepted in the same cycle as the `rom_we` pulse.
- Final accepted byte → the DONE/ERR outputs are valid on the next cycle. `cpu_rst` falls in the same cycle that `done` rises.
- `start` arriving in the same cycle as a byte while busy: the byte is processed and `start` is ignored.

## Configuration
- `HACK_LOADER_CHECKSUM_EN` defined:
  - After the data (or after the length, when N = 0), the loader accepts CHK_HI then CHK_LO.
  - The expected checksum is the 16-bit modular sum of all data words; it is 0 when N = 0.
  - Match → DONE; mismatch → ERR.
- Undefined:
  - The CHK states and the sum register are absent.
  - The final data word (or N = 0) goes directly to DONE.

## Test plan
- Reset, then idle 10 cycles → `cpu_rst` = 1, `byte_ready` = 0, `rom_we` never asserted, `done` = `err` = 0.
- `start`, then bytes 00 02 AB CD 12 34 at one per cycle → writes (0, 0xABCD) and (1, 0x1234), each `rom_we` exactly 1 cycle; `done` = 1 and `cpu_rst` = 0 one cycle after the last byte.
- `start`, then length 80 00 → `err` = 1, `cpu_rst` = 1, no writes; a subsequent `start` with 00 01 00 07 → write (0, 0x0007), then `done` = 1.
- `start`, then 00 03 with `byte_valid` toggling every other cycle and 3 words → exactly 3 writes at addresses 0, 1, 2; no write occurs on a cycle where `byte_valid` = 0.
- `rst` low after 3 data bytes → all outputs return to reset values immediately; `start` plus a full 1-word image succeeds afterwards.
- With `HACK_LOADER_CHECKSUM_EN`: 00 02 00 01 FF FF, then checksum 00 00 → DONE; the same image with checksum 00 01 → `err` = 1, `cpu_rst` = 1.
